// File: rtl/ram_group_port_arbiter_if.sv
// Requester-side bundle for one port of the URAM RAM group: request handshake
// plus the read-response return path.
interface ram_group_port_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH+1:0] req_addr;
  logic [DWIDTH-1:0] req_d;
  logic              req_lock;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_d, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_d, req_lock,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_group_port_arbiter.sv
// Round-robin (with burst lock) sharing of one RAM-group port between two
// requesters; registered issue stage and read-response routing by owner.
module ram_group_port_arbiter #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 64,
  parameter int NUM_BANKS  = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  ram_group_port_arbiter_if.slave       m0,
  ram_group_port_arbiter_if.slave       m1,
  output logic [AWIDTH-1:0]             ram_addr,
  output logic [DWIDTH-1:0]             ram_d,
  output logic [NUM_BANKS-1:0]          ram_ce,
  output logic                          ram_we,
  input  logic [NUM_BANKS*DWIDTH-1:0]   ram_q,
  output logic                          busy
);

  localparam int BANK_W = 2;
  localparam int TAIL   = RD_LATENCY - 1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_state_t;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

  lock_state_t lock_state_r, lock_next_s, lock_hold_s;
  logic        prio_r, prio_next_s;
  logic        grant0_s, grant1_s, accept_s;

  logic              sel_we_s;
  logic [AWIDTH+1:0] sel_addr_s;
  logic [DWIDTH-1:0] sel_d_s;

  logic [NUM_BANKS-1:0] ram_ce_r;
  logic                 ram_we_r;
  logic [AWIDTH-1:0]    ram_addr_r;
  logic [DWIDTH-1:0]    ram_d_r;
  logic [BANK_W-1:0]    issue_bank_r;
  logic                 issue_owner_r;

  logic [RD_LATENCY-1:0]             trk_valid_r;
  logic [RD_LATENCY-1:0]             trk_owner_r;
  logic [RD_LATENCY-1:0][BANK_W-1:0] trk_bank_r;

  logic              rsp0_hit_s, rsp1_hit_s;
  logic [DWIDTH-1:0] tail_q_s;
  logic [DWIDTH-1:0] rsp0_hold_r, rsp1_hold_r;

  // Grant selection and next lock owner / priority pointer.
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    prio_next_s = prio_r;
    lock_hold_s = lock_state_r;
    case (lock_state_r)
      LOCK_M0: grant0_s = m0.req_valid;
      LOCK_M1: grant1_s = m1.req_valid;
      LOCK_NONE: begin
        if (m0.req_valid && m1.req_valid) begin
          if (prio_r == 1'b0) begin
            grant0_s = 1'b1;
          end else begin
            grant1_s = 1'b1;
          end
          prio_next_s = ~prio_r;
        end else begin
          grant0_s = m0.req_valid;
          grant1_s = m1.req_valid;
        end
      end
      default: lock_hold_s = LOCK_NONE;
    endcase
    // The lock tracks the lock bit of every accepted beat; idle cycles keep it.
    if (grant0_s) begin
      lock_next_s = m0.req_lock ? LOCK_M0 : LOCK_NONE;
    end else if (grant1_s) begin
      lock_next_s = m1.req_lock ? LOCK_M1 : LOCK_NONE;
    end else begin
      lock_next_s = lock_hold_s;
    end
  end

  assign accept_s   = grant0_s | grant1_s;
  assign sel_we_s   = grant1_s ? m1.req_we   : m0.req_we;
  assign sel_addr_s = grant1_s ? m1.req_addr : m0.req_addr;
  assign sel_d_s    = grant1_s ? m1.req_d    : m0.req_d;

  assign m0.req_ready = grant0_s;
  assign m1.req_ready = grant1_s;

  // Arbitration state: lock owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_r <= LOCK_NONE;
      prio_r       <= 1'b0;
    end else begin
      lock_state_r <= lock_next_s;
      prio_r       <= prio_next_s;
    end
  end

  // Issue stage toward the RAM group; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ce_r      <= '0;
      ram_we_r      <= 1'b0;
      ram_addr_r    <= '0;
      ram_d_r       <= '0;
      issue_bank_r  <= '0;
      issue_owner_r <= 1'b0;
    end else if (accept_s) begin
      ram_ce_r      <= bank_onehot(sel_addr_s[AWIDTH +: BANK_W]);
      ram_we_r      <= sel_we_s;
      ram_addr_r    <= sel_addr_s[AWIDTH-1:0];
      ram_d_r       <= sel_d_s;
      issue_bank_r  <= sel_addr_s[AWIDTH +: BANK_W];
      issue_owner_r <= grant1_s;
    end else begin
      ram_ce_r <= '0;
      ram_we_r <= 1'b0;
    end
  end

  assign ram_ce   = ram_ce_r;
  assign ram_we   = ram_we_r;
  assign ram_addr = ram_addr_r;
  assign ram_d    = ram_d_r;

  // Read tracker aligned so its tail coincides with valid ram_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid_r <= '0;
      trk_owner_r <= '0;
      trk_bank_r  <= '0;
    end else begin
      trk_valid_r[0] <= (|ram_ce_r) & ~ram_we_r;
      trk_owner_r[0] <= issue_owner_r;
      trk_bank_r[0]  <= issue_bank_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        trk_valid_r[i] <= trk_valid_r[i-1];
        trk_owner_r[i] <= trk_owner_r[i-1];
        trk_bank_r[i]  <= trk_bank_r[i-1];
      end
    end
  end

  assign tail_q_s   = ram_q[int'(trk_bank_r[TAIL]) * DWIDTH +: DWIDTH];
  assign rsp0_hit_s = trk_valid_r[TAIL] & ~trk_owner_r[TAIL];
  assign rsp1_hit_s = trk_valid_r[TAIL] &  trk_owner_r[TAIL];

  // Last delivered data per requester, shown while it has no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_hold_r <= '0;
      rsp1_hold_r <= '0;
    end else begin
      if (rsp0_hit_s) begin
        rsp0_hold_r <= tail_q_s;
      end
      if (rsp1_hit_s) begin
        rsp1_hold_r <= tail_q_s;
      end
    end
  end

  assign m0.rsp_valid = rsp0_hit_s;
  assign m1.rsp_valid = rsp1_hit_s;
  assign m0.rsp_data  = rsp0_hit_s ? tail_q_s : rsp0_hold_r;
  assign m1.rsp_data  = rsp1_hit_s ? tail_q_s : rsp1_hold_r;

  assign busy = (|trk_valid_r) | (lock_state_r != LOCK_NONE);

endmodule

// File: tb/tb_ram_group_port_arbiter.sv
// Directed bench for ram_group_port_arbiter: table of request vectors with
// hand-computed grants, a behavioural RAM group and a per-cycle response check.
module tb_ram_group_port_arbiter;

  logic clk;
  logic rst;
  logic [11:0]  ram_addr;
  logic [63:0]  ram_d;
  logic [3:0]   ram_ce;
  logic         ram_we;
  logic [255:0] ram_q;
  logic         busy;

  ram_group_port_arbiter_if #(.AWIDTH(12), .DWIDTH(64)) m0_if ();
  ram_group_port_arbiter_if #(.AWIDTH(12), .DWIDTH(64)) m1_if ();

  ram_group_port_arbiter #(
    .AWIDTH(12), .DWIDTH(64), .NUM_BANKS(4), .RD_LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] pattern(input logic [1:0] b, input logic [11:0] w);
    if (b == 2'd1 && w == 12'h010) return 64'h0000_0000_0000_00A5;
    return 64'h5A00_0000_0000_0000 | {30'd0, b, 20'd0, w};
  endfunction

  // Behavioural RAM group: one input pipe stage, then a synchronous read.
  logic [63:0] mem [4][4096];
  bit          written [4][4096];
  logic [3:0]  p_ce = 4'b0000;
  logic        p_we = 1'b0;
  logic [11:0] p_addr = 12'h000;
  logic [63:0] p_d = 64'h0;
  logic [63:0] q_r [4];
  always @(posedge clk) begin
    p_ce   <= ram_ce;
    p_we   <= ram_we;
    p_addr <= ram_addr;
    p_d    <= ram_d;
    for (int b = 0; b < 4; b++) begin
      if (p_ce[b]) begin
        if (p_we) begin
          mem[b][p_addr]     <= p_d;
          written[b][p_addr] <= 1'b1;
        end else begin
          q_r[b] <= written[b][p_addr] ? mem[b][p_addr] : pattern(2'(b), p_addr);
        end
      end
    end
  end
  assign ram_q = {q_r[3], q_r[2], q_r[1], q_r[0]};

  // Bench-side expected memory contents, updated from predicted write grants.
  logic [63:0] exp_mem [4][4096];
  bit          exp_wr  [4][4096];
  function automatic logic [63:0] exp_read(input logic [13:0] a);
    return exp_wr[a[13:12]][a[11:0]] ? exp_mem[a[13:12]][a[11:0]] : pattern(a[13:12], a[11:0]);
  endfunction

  bit          exp_v0 [4096];
  bit          exp_v1 [4096];
  logic [63:0] exp_d0 [4096];
  logic [63:0] exp_d1 [4096];
  logic [63:0] last0 = 64'h0;
  logic [63:0] last1 = 64'h0;
  bit          mon_en = 1'b0;
  bit          no_rsp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every cycle, each requester must match the prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rsp0_valid", m0_if.rsp_valid, exp_v0[cyc]);
      chk("rsp1_valid", m1_if.rsp_valid, exp_v1[cyc]);
      if (exp_v0[cyc]) last0 = exp_d0[cyc];
      if (exp_v1[cyc]) last1 = exp_d1[cyc];
      chk("rsp0_data", m0_if.rsp_data, last0);
      chk("rsp1_data", m1_if.rsp_data, last1);
    end
  end

  typedef struct {
    string       name;
    bit          v0, we0, lk0;
    logic [13:0] a0;
    logic [63:0] d0;
    bit          v1, we1, lk1;
    logic [13:0] a1;
    logic [63:0] d1;
    bit          r0, r1;
    logic [3:0]  ce;
    bit          we;
  } vec_t;

  function automatic vec_t mk(input string n,
      input bit v0, input bit we0, input bit lk0, input logic [13:0] a0, input logic [63:0] d0,
      input bit v1, input bit we1, input bit lk1, input logic [13:0] a1, input logic [63:0] d1,
      input bit r0, input bit r1, input logic [3:0] ce, input bit we);
    vec_t v;
    v.name = n;
    v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.ce = ce; v.we = we;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk("idle", 0, 0, 0, 14'h0, 64'h0, 0, 0, 0, 14'h0, 64'h0, 0, 0, 4'b0000, 0);
  endfunction

  // Drive one cycle of requests, check grants mid-cycle and the issue stage after the edge.
  task automatic apply(input vec_t v);
    bit          g0, g1, gwe;
    logic [13:0] ga;
    logic [63:0] gd;
    m0_if.req_valid = v.v0; m0_if.req_we = v.we0; m0_if.req_lock = v.lk0;
    m0_if.req_addr  = v.a0; m0_if.req_d  = v.d0;
    m1_if.req_valid = v.v1; m1_if.req_we = v.we1; m1_if.req_lock = v.lk1;
    m1_if.req_addr  = v.a1; m1_if.req_d  = v.d1;
    @(negedge clk);
    chk({v.name, "_ready0"}, m0_if.req_ready, v.r0);
    chk({v.name, "_ready1"}, m1_if.req_ready, v.r1);
    g0  = v.v0 && v.r0;
    g1  = v.v1 && v.r1;
    ga  = g1 ? v.a1  : v.a0;
    gd  = g1 ? v.d1  : v.d0;
    gwe = g1 ? v.we1 : v.we0;
    if (g0 || g1) begin
      if (gwe) begin
        exp_wr[ga[13:12]][ga[11:0]]  = 1'b1;
        exp_mem[ga[13:12]][ga[11:0]] = gd;
      end else if (!no_rsp) begin
        if (g1) begin
          exp_v1[cyc+3] = 1'b1;
          exp_d1[cyc+3] = exp_read(ga);
        end else begin
          exp_v0[cyc+3] = 1'b1;
          exp_d0[cyc+3] = exp_read(ga);
        end
      end
    end
    @(posedge clk); #1;
    chk({v.name, "_ram_ce"}, ram_ce, v.ce);
    chk({v.name, "_ram_we"}, ram_we, v.we);
    if (v.ce != 4'b0000) chk({v.name, "_ram_addr"}, ram_addr, ga[11:0]);
    if (v.we) chk({v.name, "_ram_d"}, ram_d, gd);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk("m0_rd",    1,0,0,{2'd1,12'h010},64'h0, 0,0,0,14'h0,64'h0,             1,0,4'b0010,0));
    tbl.push_back(idle()); tbl.push_back(idle()); tbl.push_back(idle());
    tbl.push_back(mk("tie_a",    1,0,0,{2'd0,12'h001},64'h0, 1,0,0,{2'd3,12'h002},64'h0,    1,0,4'b0001,0));
    tbl.push_back(mk("tie_b",    1,0,0,{2'd0,12'h003},64'h0, 1,0,0,{2'd3,12'h002},64'h0,    0,1,4'b1000,0));
    tbl.push_back(mk("tie_c",    1,0,0,{2'd0,12'h003},64'h0, 1,0,0,{2'd3,12'h004},64'h0,    1,0,4'b0001,0));
    tbl.push_back(mk("tie_d",    1,0,0,{2'd0,12'h005},64'h0, 1,0,0,{2'd3,12'h004},64'h0,    0,1,4'b1000,0));
    tbl.push_back(mk("tie_e",    1,0,0,{2'd0,12'h005},64'h0, 1,0,0,{2'd3,12'h006},64'h0,    1,0,4'b0001,0));
    tbl.push_back(mk("lk_w1",    1,0,0,{2'd0,12'h007},64'h0, 1,1,1,{2'd2,12'h020},64'h111,  0,1,4'b0100,1));
    tbl.push_back(mk("lk_w2",    1,0,0,{2'd0,12'h007},64'h0, 1,1,1,{2'd2,12'h021},64'h222,  0,1,4'b0100,1));
    tbl.push_back(mk("lk_w3",    1,0,0,{2'd0,12'h007},64'h0, 1,1,0,{2'd2,12'h022},64'h333,  0,1,4'b0100,1));
    tbl.push_back(mk("after_lk", 1,0,0,{2'd0,12'h007},64'h0, 0,0,0,14'h0,64'h0,             1,0,4'b0001,0));
    tbl.push_back(mk("own_lk",   1,0,1,{2'd1,12'h030},64'h0, 1,0,0,{2'd3,12'h031},64'h0,    1,0,4'b0010,0));
    tbl.push_back(mk("own_idle", 0,0,0,14'h0,64'h0,          1,0,0,{2'd3,12'h031},64'h0,    0,0,4'b0000,0));
    tbl.push_back(mk("own_rel",  1,0,0,{2'd1,12'h032},64'h0, 1,0,0,{2'd3,12'h031},64'h0,    1,0,4'b0010,0));
    tbl.push_back(mk("m1_go",    0,0,0,14'h0,64'h0,          1,0,0,{2'd3,12'h031},64'h0,    0,1,4'b1000,0));
    tbl.push_back(mk("rd_wr",    1,0,0,{2'd2,12'h021},64'h0, 0,0,0,14'h0,64'h0,             1,0,4'b0100,0));
    for (int i = 0; i < 4; i++) tbl.push_back(idle());

    rst = 1'b1;
    m0_if.req_valid = 1'b0; m0_if.req_we = 1'b0; m0_if.req_lock = 1'b0;
    m0_if.req_addr  = 14'h0; m0_if.req_d = 64'h0;
    m1_if.req_valid = 1'b0; m1_if.req_we = 1'b0; m1_if.req_lock = 1'b0;
    m1_if.req_addr  = 14'h0; m1_if.req_d = 64'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ram_ce",   ram_ce, 4'b0000);
    chk("rst_ram_we",   ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 12'h000);
    chk("rst_ram_d",    ram_d, 64'h0);
    chk("rst_busy",     busy, 1'b0);
    chk("rst_rsp0_v",   m0_if.rsp_valid, 1'b0);
    chk("rst_rsp1_v",   m1_if.rsp_valid, 1'b0);
    chk("rst_rsp0_d",   m0_if.rsp_data, 64'h0);
    chk("rst_rsp1_d",   m1_if.rsp_data, 64'h0);
    mon_en = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);
    chk("drained_busy", busy, 1'b0);

    // Write then read the same word on consecutive cycles.
    apply(mk("wr_fff", 1,1,0,{2'd2,12'hFFF},64'hDEADBEEF, 0,0,0,14'h0,64'h0, 1,0,4'b0100,1));
    apply(mk("rd_fff", 1,0,0,{2'd2,12'hFFF},64'h0,        0,0,0,14'h0,64'h0, 1,0,4'b0100,0));
    repeat (4) apply(idle());

    // Lock alone keeps busy high, release drops it.
    apply(mk("wlk_on",  1,1,1,{2'd1,12'h100},64'hAA, 0,0,0,14'h0,64'h0, 1,0,4'b0010,1));
    chk("lock_busy", busy, 1'b1);
    apply(mk("wlk_off", 1,1,0,{2'd1,12'h101},64'hBB, 0,0,0,14'h0,64'h0, 1,0,4'b0010,1));
    chk("unlock_busy", busy, 1'b0);

    // Back-to-back reads of words 0..7 give eight gap-free responses.
    for (int i = 0; i < 8; i++)
      apply(mk("b2b", 1,0,0,{2'd0,12'(i)},64'h0, 0,0,0,14'h0,64'h0, 1,0,4'b0001,0));
    repeat (4) apply(idle());

    // Reset with two reads in flight: they must never respond.
    no_rsp = 1'b1;
    apply(mk("pre_rst0", 1,0,0,{2'd1,12'h005},64'h0, 0,0,0,14'h0,64'h0,          1,0,4'b0010,0));
    apply(mk("pre_rst1", 0,0,0,14'h0,64'h0,          1,0,0,{2'd3,12'h006},64'h0, 0,1,4'b1000,0));
    chk("inflight_busy", busy, 1'b1);
    m1_if.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    no_rsp = 1'b0;
    last0 = 64'h0;
    last1 = 64'h0;
    chk("mid_rst_ram_ce", ram_ce, 4'b0000);
    chk("mid_rst_ram_we", ram_we, 1'b0);
    chk("mid_rst_busy",   busy, 1'b0);
    apply(mk("post_rst_tie", 1,0,0,{2'd0,12'h008},64'h0, 1,0,0,{2'd3,12'h009},64'h0, 1,0,4'b0001,0));
    apply(mk("post_rst_m1",  0,0,0,14'h0,64'h0,          1,0,0,{2'd3,12'h009},64'h0, 0,1,4'b1000,0));
    repeat (5) apply(idle());

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_group_port_arbiter.md
Name: ram_group_port_arbiter

Overview:
- Shares one port (port 0 or port 1) of the 4-bank URAM RAM group between two requesters, e.g. a DMA engine (m0) and a compute kernel (m1).
- Performs round-robin arbitration with optional lock (burst hold).
- Drives registered bank-select, address, data and write-enable toward the RAM group.
- Tracks in-flight reads through the group's fixed read latency and routes each read response back to the requester that issued it.

Parameters:
AWIDTH, 12, word address width inside one bank
DWIDTH, 64, data width
NUM_BANKS, 4, banks in the group; request address is {bank[1:0], word[AWIDTH-1:0]}
RD_LATENCY, 2, cycles from ram_ce/ram_addr driven by this block to ram_q valid (1 input pipe stage + 1 sync RAM read)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
m0_req_valid  in  1  m0 request valid
m0_req_ready  out  1  m0 request accepted this cycle (combinational grant)
m0_req_we  in  1  1 = write, 0 = read
m0_req_addr  in  AWIDTH+2  {bank, word}
m0_req_d  in  DWIDTH  write data
m0_req_lock  in  1  hold grant on m0 after this beat
m0_rsp_valid  out  1  read data valid for m0
m0_rsp_data  out  DWIDTH  read data for m0
m1_*  (same set as m0)  requester 1
ram_addr  out  AWIDTH  word address to all banks
ram_d  out  DWIDTH  write data to all banks
ram_ce  out  NUM_BANKS  one-hot bank enable
ram_we  out  1  write enable (qualified by ram_ce)
ram_q  in  NUM_BANKS*DWIDTH  bank read data, bank b at [b*DWIDTH +: DWIDTH]
busy  out  1  any read in flight or grant locked

Behaviour:
- Reset values: ram_ce=0, ram_we=0, ram_addr=0, ram_d=0; m0/m1_rsp_valid=0, rsp_data=0; priority pointer=m0; lock owner=none; read tracker cleared; busy=0.
- Reset mid-operation: in-flight reads are dropped and no rsp_valid is produced for them.
- Arbitration (combinational, each cycle):
  - Locked to mN: only mN can be granted; mN_req_ready=mN_req_valid; other ready=0.
  - Unlocked, one valid: that requester is granted.
  - Unlocked, both valid: grant the priority-pointer holder; pointer moves to the other requester after each both-valid grant.
  - A single-requester grant leaves the pointer unchanged.
- Lock:
  - An accepted beat with mN_req_lock=1 sets lock owner=mN from the next cycle.
  - An accepted beat from the owner with lock=0 releases the lock after that beat.
  - While locked, an idle owner (valid=0) keeps the lock; the other requester stalls.
- Issue stage (registered):
  - On an accepted beat, next cycle: ram_ce=onehot(addr[AWIDTH+1:AWIDTH]), ram_we=we, ram_addr=addr[AWIDTH-1:0], ram_d=d.
  - No accept: ram_ce=0, ram_we=0; addr and d hold their last values.
  - Throughput: 1 beat/cycle; no bubbles between back-to-back grants.
- Read tracking:
  - RD_LATENCY-deep shift register of {valid, owner, bank}, fed from the issue stage when ram_ce!=0 and ram_we=0.
  - At the tail: mN_rsp_valid=1 for exactly one cycle; mN_rsp_data=ram_q slice of the tracked bank.
  - Response latency from accept to rsp_valid is RD_LATENCY+1 = 3 cycles at default.
  - Responses are in issue order; no backpressure (requesters must sink rsp every cycle).
  - The non-target requester sees rsp_valid=0 and rsp_data holding its previous value.
- Writes: no response; a read issued the cycle after a write to the same address returns the new data (the RAM group orders port accesses by cycle).
- busy = any tracker valid | lock owner!=none.

Test Plan:
- Single m0 read: addr={2'd1,12'h010}, bank1 q=64'hA5 at the right cycle -> m0_req_ready same cycle; ram_ce=4'b0010, ram_addr=12'h010 at accept+1; m0_rsp_valid, data=64'hA5 at accept+3; m1_rsp_valid stays 0.
- Both requesters valid for 4 cycles, reads to bank0/bank3 -> grants m0,m1,m0,m1; each response returns to the correct requester with the correct bank data, 3 cycles after its grant.
- m1 issues 3 writes with lock=1,1,0 while m0 is continuously valid -> m0_req_ready=0 for all 3 beats; m0 is granted on the 4th cycle; ram_we=1 on 3 consecutive cycles.
- Write 64'hDEADBEEF to {2'd2,12'hFFF}, then read the same address next cycle -> ram_ce=4'b0100 on both beats; rsp_data=64'hDEADBEEF.
- Assert rst one cycle after two reads are accepted -> ram_ce=0 and rsp_valid never asserts for those reads; busy=0; pointer=m0 (m0 wins the first tie after reset).
- Back-to-back m0 reads at word addresses 0..7 -> 8 consecutive rsp_valid cycles with data in address order, no gaps.
